// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared mode/state encodings and default constants for cpu_clock_gen
package clkgen_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   localparam int DIV_DEFAULT = 12499;
   localparam int DB_CYCLES   = 16;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - counter-based stability filter for the step input
// Instantiated by cpu_clock_gen only when CLKGEN_DEBOUNCE_EN is defined.
module step_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic CLK,
   input  logic CLRn,
   input  logic in,
   output logic out
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          r_out;
   logic [CW-1:0] r_cnt;

   // out follows in only after DB_CYCLES consecutive differing samples
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         r_out <= 1'b0;
         r_cnt <= '0;
      end else if (in == r_out) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
         r_out <= in;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign out = r_out;

endmodule

// File: rtl/cpu_clock_gen.sv
// rtl/cpu_clock_gen.sv - divided CPU clock T/tick with RUN/HALT/STEP FSM and divisor load
// Optional step debounce selected by CLKGEN_DEBOUNCE_EN.
module cpu_clock_gen #(
   parameter int CNT_W       = 26,
   parameter int DIV_DEFAULT = clkgen_pkg::DIV_DEFAULT,
   parameter int DB_CYCLES   = clkgen_pkg::DB_CYCLES
) (
   input  logic             CLK,
   input  logic             CLRn,
   input  logic [1:0]       mode,
   input  logic             step,
   input  logic             div_ld,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             T,
   output logic             tick,
   output logic             busy
);
   import clkgen_pkg::*;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_div, r_shadow;
   logic             r_pending, r_div_ack;
   logic             r_t, w_t_nxt, r_tick, w_tick_nxt, r_busy;
   logic             r_sync1, r_sync2, r_step_prev;
   logic             w_step_lvl, w_step_edge, w_tc, w_apply;
   logic [CNT_W-1:0] w_div_clamp;

   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_step_prev <= 1'b0;
      end else begin
         r_sync1     <= step;
         r_sync2     <= r_sync1;
         r_step_prev <= w_step_lvl;
      end
   end

`ifdef CLKGEN_DEBOUNCE_EN
   step_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_debounce (
      .CLK  (CLK),
      .CLRn (CLRn),
      .in   (r_sync2),
      .out  (w_step_lvl)
   );
`else
   assign w_step_lvl = r_sync2;
`endif

   assign w_step_edge = w_step_lvl & ~r_step_prev;
   assign w_tc        = (r_state != ST_IDLE) && (r_cnt == r_div);
   assign w_div_clamp = (div_val == '0) ? CNT_W'(1) : div_val;
   assign w_apply     = r_pending && ((r_state == ST_IDLE) || w_tc);

   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_t     <= 1'b0;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_t     <= w_t_nxt;
         r_tick  <= w_tick_nxt;
         r_busy  <= (w_state_nxt == ST_STEP);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_t_nxt     = r_t;
      w_tick_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (mode == MODE_RUN)
               w_state_nxt = ST_RUN;
            else if ((mode == MODE_STEP) && w_step_edge)
               w_state_nxt = ST_STEP;
         end
         ST_RUN: begin
            w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
            // low phase can be cut short; high phase always runs to terminal count
            if ((mode != MODE_RUN) && !r_t) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_tc) begin
               w_t_nxt    = ~r_t;
               w_tick_nxt = ~r_t;
               if (mode != MODE_RUN)
                  w_state_nxt = ST_IDLE;
            end
         end
         ST_STEP: begin
            w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
            if (w_tc) begin
               w_t_nxt    = ~r_t;
               w_tick_nxt = ~r_t;
               if (r_t)
                  w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_t_nxt     = 1'b0;
         end
      endcase
   end

   // a load in the same cycle as an apply re-arms pending with the newer value
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         r_div     <= CNT_W'(DIV_DEFAULT);
         r_shadow  <= CNT_W'(DIV_DEFAULT);
         r_pending <= 1'b0;
         r_div_ack <= 1'b0;
      end else begin
         r_div_ack <= 1'b0;
         if (w_apply) begin
            r_div     <= r_shadow;
            r_pending <= 1'b0;
            r_div_ack <= 1'b1;
         end
         if (div_ld) begin
            r_shadow  <= w_div_clamp;
            r_pending <= 1'b1;
         end
      end
   end

   assign T       = r_t;
   assign tick    = r_tick;
   assign busy    = r_busy;
   assign div_ack = r_div_ack;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb/tb_cpu_clock_gen.sv - directed self-checking bench for cpu_clock_gen
// Debounce scenario runs only when CLKGEN_DEBOUNCE_EN is defined.
module tb_cpu_clock_gen;
   import clkgen_pkg::*;

   localparam int TB_CNT_W   = 26;
   localparam int TB_DIV_DEF = 5;

   logic                CLK;
   logic                CLRn;
   logic [1:0]          mode;
   logic                step;
   logic                div_ld;
   logic [TB_CNT_W-1:0] div_val;
   logic                div_ack;
   logic                T;
   logic                tick;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int n, hi, ticks, bsy;

   cpu_clock_gen #(
      .CNT_W       (TB_CNT_W),
      .DIV_DEFAULT (TB_DIV_DEF),
      .DB_CYCLES   (4)
   ) dut (
      .CLK     (CLK),
      .CLRn    (CLRn),
      .mode    (mode),
      .step    (step),
      .div_ld  (div_ld),
      .div_val (div_val),
      .div_ack (div_ack),
      .T       (T),
      .tick    (tick),
      .busy    (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step_clk();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tick(input int max, output int cnt);
      cnt = -1;
      for (int i = 1; i <= max; i++) begin
         step_clk();
         if (tick === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      CLRn = 1'b0; mode = MODE_HALT; step = 1'b0; div_ld = 1'b0; div_val = '0;
      step_clk(); step_clk();
      chk("rst_T", T, 0); chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0); chk("rst_ack", div_ack, 0);
      CLRn = 1'b1;
      step_clk();

      div_ld = 1'b1; div_val = 3; step_clk(); div_ld = 1'b0;
      chk("idle_ld_ack_wait", div_ack, 0);
      step_clk(); chk("idle_ld_ack", div_ack, 1);
      step_clk(); chk("idle_ld_ack_clr", div_ack, 0);

      mode = MODE_RUN; step_clk();
      wait_tick(50, n); chk("run_first_tick", n, 4); chk("run_T_hi", T, 1);
      hi = 1; ticks = 0;
      for (int i = 1; i <= 7; i++) begin
         step_clk(); hi += int'(T); ticks += int'(tick);
      end
      chk("run_hi_cycles", hi, 4); chk("run_mid_ticks", ticks, 0);
      step_clk(); chk("run_tick_period", tick, 1);

      step_clk(); mode = MODE_HALT;
      step_clk(); chk("halt_T_hold1", T, 1);
      step_clk(); chk("halt_T_hold2", T, 1);
      step_clk(); chk("halt_T_fall", T, 0);
      hi = 0; ticks = 0;
      for (int i = 0; i < 20; i++) begin
         step_clk(); hi += int'(T); ticks += int'(tick);
      end
      chk("halt_no_tick", ticks, 0); chk("halt_T_low", hi, 0);

      div_ld = 1'b1; div_val = 2; step_clk(); div_ld = 1'b0;
      step_clk(); chk("step_div_ack", div_ack, 1);
      mode = MODE_STEP;
      step = 1'b1;
      step_clk(); chk("step_busy_k", busy, 0);
      step_clk(); chk("step_busy_k1", busy, 0); step = 1'b0;
      step_clk(); chk("step_busy_k2", busy, 1);
      step = 1'b1;
      step_clk(); chk("step_T_k3", T, 0);
      step_clk(); chk("step_T_k4", T, 0); step = 1'b0;
      step_clk(); chk("step_T_rise", T, 1); chk("step_tick", tick, 1);
      step_clk(); chk("step_T_hi2", T, 1); chk("step_tick_clr", tick, 0);
      step_clk(); chk("step_T_hi3", T, 1); chk("step_busy_hi", busy, 1);
      step_clk(); chk("step_T_fall", T, 0); chk("step_busy_drop", busy, 0);
      ticks = 0; bsy = 0;
      for (int i = 0; i < 16; i++) begin
         step_clk(); ticks += int'(tick); bsy += int'(busy);
      end
      chk("step_discard_tick", ticks, 0); chk("step_discard_busy", bsy, 0);

      div_ld = 1'b1; div_val = 3; step_clk(); div_ld = 1'b0;
      step_clk(); chk("div3_ack", div_ack, 1);
      mode = MODE_RUN; step_clk();
      wait_tick(50, n); chk("div3_first", n, 4);
      step_clk();
      div_ld = 1'b1; div_val = 5; step_clk();
      div_val = 7; step_clk(); chk("div_no_early_ack", div_ack, 0);
      div_ld = 1'b0; step_clk();
      chk("div_ack_tc", div_ack, 1); chk("div_T_fall", T, 0);
      step_clk(); chk("div_ack_single", div_ack, 0);
      wait_tick(50, n); chk("div7_rise", n, 7);
      wait_tick(50, n); chk("div7_period", n, 16);

      div_ld = 1'b1; div_val = 0; step_clk(); div_ld = 1'b0;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step_clk();
         if (div_ack === 1'b1) begin
            n = i;
            break;
         end
      end
      chk("clamp_ack", n, 7);
      wait_tick(50, n); chk("clamp_rise", n, 2);
      wait_tick(50, n); chk("clamp_period", n, 4);

      mode = MODE_HALT;
      repeat (4) step_clk();
      chk("pre_rst_T", T, 0);
      mode = MODE_STEP; step = 1'b1;
      step_clk(); step_clk(); step = 1'b0;
      step_clk(); chk("rst_step_busy", busy, 1);
      step_clk(); step_clk();
      chk("rst_step_T", T, 1); chk("rst_step_tick", tick, 1);
      #3 CLRn = 1'b0;
      #1;
      chk("async_T", T, 0); chk("async_busy", busy, 0); chk("async_tick", tick, 0);
      step_clk(); CLRn = 1'b1; mode = MODE_RUN;
      step_clk();
      wait_tick(50, n); chk("default_div_first", n, TB_DIV_DEF + 1);
      wait_tick(50, n); chk("default_div_period", n, 2 * (TB_DIV_DEF + 1));

`ifdef CLKGEN_DEBOUNCE_EN
      mode = MODE_HALT;
      repeat (14) step_clk();
      mode = MODE_STEP; step = 1'b1;
      repeat (3) step_clk();
      step = 1'b0; bsy = 0;
      for (int i = 0; i < 20; i++) begin
         step_clk(); bsy += int'(busy);
      end
      chk("db_glitch_ignored", bsy, 0);
      step = 1'b1; ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step_clk(); ticks += int'(tick);
      end
      step = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step_clk(); ticks += int'(tick);
      end
      chk("db_held_one_step", ticks, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_clock_gen.md
# cpu_clock_gen

Parametrised CPU clock source for the 8-bit CPU model. It divides the board clock into a square-wave CPU clock `T` and a matching one-cycle `tick` strobe. The divisor can be changed at runtime through a load handshake, and a mode FSM supports free-run, clean halt and single-step. It sits between the board clock/reset/front-panel inputs and every CPU block that advances on the CPU clock.

## Interface
- `CNT_W`, 26: divider counter and divisor width.
- `DIV_DEFAULT`, 12499: divisor after reset; `T` period = 2·(div+1) CLK cycles.
- `DB_CYCLES`, 16: debounce stability window in CLK cycles; used only with `CLKGEN_DEBOUNCE_EN`.
- `CLK` in 1: board clock; all state changes on its rising edge.
- `CLRn` in 1: reset, asynchronous, active-low.
- `mode` in 2: 00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
- `step` in 1: asynchronous front-panel step request, level.
- `div_ld` in 1: one-cycle request to load `div_val`.
- `div_val` in CNT_W: new divisor; values 0 are clamped to 1.
- `div_ack` out 1: one-cycle pulse when a divisor actually takes effect.
- `T` out 1: CPU clock, registered square wave.
- `tick` out 1: registered, high for exactly the CLK cycle in which `T` is 1 for the first time in a period.
- `busy` out 1: high while a single step is in progress.

## Operation
- Counter `cnt` runs 0..`div_reg`. Terminal count is `cnt == div_reg`; at terminal count `cnt` wraps to 0. `cnt` is held at 0 in IDLE.
- FSM states and transitions:
  - IDLE → RUN: when `mode == RUN`.
  - IDLE → STEP: when `mode == STEP` and a step rising edge is detected.
  - RUN: `T` toggles at every terminal count.
  - RUN → IDLE, mode no longer RUN, `T == 0`: leave immediately and clear `cnt`.
  - RUN → IDLE, mode no longer RUN, `T == 1`: wait for the next terminal count, drive `T` low, then enter IDLE. No runt pulses.
  - STEP: `T` rises at the 1st terminal count and falls at the 2nd, then the FSM returns to IDLE. Exactly one full period.
  - STEP always completes, even if `mode` changes during it.
- Step input path: 2-flop synchroniser, then edge register. Edge = sync & ~prev. Edges while `busy` or outside IDLE/STEP mode are discarded, not queued.
- Divisor update:
  - `div_ld` writes the clamped `div_val` into a shadow register and sets a pending flag.
  - A later `div_ld` before application overwrites the shadow; only one `div_ack` is produced.
  - Pending applies at the next terminal count, or on the next CLK edge if the FSM is in IDLE.
  - If `div_ld` coincides with a terminal count, the new value applies at the following terminal count.
  - `cnt` never exceeds `div_reg`.
- Reset state: `cnt` 0, `T` 0, `tick` 0, `busy` 0, `div_ack` 0, `div_reg = DIV_DEFAULT`, pending 0, state IDLE, synchroniser flops 0.
- A reset asserted mid-step or mid-period aborts it asynchronously; `T` drops immediately.

## Timing
- RUN from IDLE: first `T` rise (`tick`) occurs `div_reg+1` CLK edges after the edge that entered RUN. Afterwards `tick` repeats every 2·(`div_reg`+1) cycles.
- Step latency: with `step` first sampled high at edge k, `busy` is 1 after edge k+2. `T` rises after `div_reg`+1 further edges and falls `div_reg`+1 edges after that. `busy` drops on the same edge `T` falls.
- `div_ack` is high on the same edge at which `div_reg` changes.
- `tick` and `T` are both registered; `tick` and the `T` rise appear on the same edge.
- Minimum `T` period is 4 CLK cycles (div = 1).

## Configuration
- Macro `CLKGEN_DEBOUNCE_EN`.
- Defined: the synchronised step is fed through `step_debounce`. The debounced level changes only after the input has been stable for `DB_CYCLES` consecutive CLK cycles. Step latency grows by `DB_CYCLES`, and glitches shorter than the window are ignored.
- Undefined: synchroniser and edge detect only; `DB_CYCLES` is unused and no debounce logic is generated.

## Structure
- Shared package `clkgen_pkg`:
  - mode encodings `MODE_HALT`/`MODE_RUN`/`MODE_STEP`;
  - FSM state encodings IDLE/RUN/STEP;
  - default constants `DIV_DEFAULT` and `DB_CYCLES`.
- One sub-module, `step_debounce`: a counter-based stability filter with `CLK`, `CLRn`, `in`, `out` and parameter `DB_CYCLES`. It is instantiated only under the macro.

## Test plan
- Reset, then `mode=RUN`, div=3 → first `tick` 4 cycles after entering RUN; `T` period 8 cycles, 4 high / 4 low; `tick` every 8 cycles.
- RUN with div=3, `mode→HALT` while `T=1` at `cnt=1` → `T` stays high 2 more cycles, falls at terminal count, state IDLE, no further `tick`.
- `mode=STEP`, div=2, single `step` pulse → `busy` set 2 edges later; exactly one `T` period (3 high, 3 low) and one `tick`. A second step pulse while `busy` produces nothing.
- RUN with div=3, `div_ld` with 5 then 7 before the next terminal count → single `div_ack` at that terminal count; subsequent period 16; `div_val=0` load yields period 4.
- Async `CLRn` low mid-step → `T`, `busy`, `tick` go to 0 immediately; `div_reg` returns to `DIV_DEFAULT`.
- With `CLKGEN_DEBOUNCE_EN` and `DB_CYCLES=4`: a 3-cycle `step` glitch → no step; a `step` held 10 cycles → exactly one step.
